// File: rtl/cmp_pkg.sv
// Shared definitions for the windowed min/max comparator: the control states and
// the comparison-mode encodings used by the datapath and the comparator core.
package cmp_pkg;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic CMP_UNSIGNED = 1'b0;
   localparam logic CMP_SIGNED   = 1'b1;

endpackage : cmp_pkg

// File: rtl/cmp_core.sv
// Combinational magnitude comparator: strict a<b and a>b, unsigned or two's-complement.
// Signed order is obtained by flipping both MSBs, which maps two's-complement onto offset binary.
module cmp_core
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             lt,
   output logic             gt
);

   logic [WIDTH-1:0] bias;
   logic [WIDTH-1:0] a_biased;
   logic [WIDTH-1:0] b_biased;

   // Same width on both sides, so -2^(W-1) and 2^(W-1)-1 land on 0 and all-ones.
   assign bias     = {(signed_mode == CMP_SIGNED), {(WIDTH-1){1'b0}}};
   assign a_biased = a ^ bias;
   assign b_biased = b ^ bias;

   assign lt = (a_biased < b_biased);
   assign gt = (a_biased > b_biased);

endmodule : cmp_core

// File: rtl/cmp_window_minmax.sv
// Collects COUNT samples per window and presents their min/max with first-occurrence indices.
// Define CMP_WINDOW_RANGE_EN to add the registered out_range = out_max - out_min output.
module cmp_window_minmax
   import cmp_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int COUNT = 4,
   localparam int IW    = $clog2(COUNT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_min,
   output logic [WIDTH-1:0] out_max,
   output logic [IW-1:0]    out_min_idx,
   output logic [IW-1:0]    out_max_idx,
   output logic             out_signed
`ifdef CMP_WINDOW_RANGE_EN
   ,
   output logic [WIDTH:0]   out_range
`endif
);

   // Control and running window state
   state_t           state_q,   state_d;
   logic [IW-1:0]    count_q,   count_d;
   logic [WIDTH-1:0] min_q,     min_d;
   logic [WIDTH-1:0] max_q,     max_d;
   logic [IW-1:0]    min_idx_q, min_idx_d;
   logic [IW-1:0]    max_idx_q, max_idx_d;
   logic             mode_q,    mode_d;

   // Result registers, loaded only when a window closes
   logic [WIDTH-1:0] res_min_q;
   logic [WIDTH-1:0] res_max_q;
   logic [IW-1:0]    res_min_idx_q;
   logic [IW-1:0]    res_max_idx_q;
   logic             res_signed_q;

   logic xfer;
   logic first;
   logic last;
   logic min_lt, min_gt;
   logic max_lt, max_gt;
   logic unused_cmp;

   cmp_core #(.WIDTH(WIDTH)) u_cmp_min (
      .a           (in_data),
      .b           (min_q),
      .signed_mode (mode_q),
      .lt          (min_lt),
      .gt          (min_gt)
   );

   cmp_core #(.WIDTH(WIDTH)) u_cmp_max (
      .a           (in_data),
      .b           (max_q),
      .signed_mode (mode_q),
      .lt          (max_lt),
      .gt          (max_gt)
   );

   assign unused_cmp = min_gt ^ max_lt;

   // in_ready drops combinationally with rst so nothing is taken while reset is held.
   assign in_ready  = (state_q == ACCUM) && !rst;
   assign out_valid = (state_q == HOLD);

   assign xfer  = (state_q == ACCUM) && in_valid;
   assign first = (count_q == '0);
   assign last  = xfer && (count_q == IW'(COUNT - 1));

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      min_d     = min_q;
      max_d     = max_q;
      min_idx_d = min_idx_q;
      max_idx_d = max_idx_q;
      mode_d    = mode_q;

      if (xfer) begin
         count_d = last ? '0 : count_q + IW'(1);
         if (first) begin
            min_d     = in_data;
            max_d     = in_data;
            min_idx_d = '0;
            max_idx_d = '0;
            mode_d    = signed_mode;
         end else begin
            // Strict compares keep the earliest index on ties.
            if (min_lt) begin
               min_d     = in_data;
               min_idx_d = count_q;
            end
            if (max_gt) begin
               max_d     = in_data;
               max_idx_d = count_q;
            end
         end
      end

      case (state_q)
         ACCUM:   if (last)      state_d = HOLD;
         HOLD:    if (out_ready) state_d = ACCUM;
         default:                state_d = ACCUM;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ACCUM;
         count_q   <= '0;
         min_q     <= '0;
         max_q     <= '0;
         min_idx_q <= '0;
         max_idx_q <= '0;
         mode_q    <= CMP_UNSIGNED;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         min_q     <= min_d;
         max_q     <= max_d;
         min_idx_q <= min_idx_d;
         max_idx_q <= max_idx_d;
         mode_q    <= mode_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_min_q     <= '0;
         res_max_q     <= '0;
         res_min_idx_q <= '0;
         res_max_idx_q <= '0;
         res_signed_q  <= CMP_UNSIGNED;
      end else if (last) begin
         res_min_q     <= min_d;
         res_max_q     <= max_d;
         res_min_idx_q <= min_idx_d;
         res_max_idx_q <= max_idx_d;
         res_signed_q  <= mode_q;
      end
   end

   assign out_min     = res_min_q;
   assign out_max     = res_max_q;
   assign out_min_idx = res_min_idx_q;
   assign out_max_idx = res_max_idx_q;
   assign out_signed  = res_signed_q;

`ifdef CMP_WINDOW_RANGE_EN
   logic [WIDTH-1:0] range_bias;
   logic [WIDTH:0]   range_d;
   logic [WIDTH:0]   range_q;

   // Offset-binary difference is the true span in either mode and never negative.
   assign range_bias = {mode_q, {(WIDTH-1){1'b0}}};
   assign range_d    = {1'b0, max_d ^ range_bias} - {1'b0, min_d ^ range_bias};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       range_q <= '0;
      else if (last) range_q <= range_d;
   end

   assign out_range = range_q;
`endif

endmodule : cmp_window_minmax

// File: tb/tb_cmp_window_minmax.sv
// Self-checking bench for cmp_window_minmax: queue-based window model plus directed vectors.
// Range checks are compiled in when CMP_WINDOW_RANGE_EN is defined.
module tb_cmp_window_minmax;

   localparam int WIDTH = 8;
   localparam int COUNT = 4;
   localparam int IW    = $clog2(COUNT);

   typedef logic [WIDTH-1:0] data_q_t[$];

   typedef struct {
      logic [WIDTH-1:0] mn;
      logic [WIDTH-1:0] mx;
      int               mn_i;
      int               mx_i;
      logic             sg;
      logic [WIDTH:0]   rng;
   } res_t;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             signed_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_min;
   logic [WIDTH-1:0] out_max;
   logic [IW-1:0]    out_min_idx;
   logic [IW-1:0]    out_max_idx;
   logic             out_signed;
`ifdef CMP_WINDOW_RANGE_EN
   logic [WIDTH:0]   out_range;
`endif

   int tests = 0;
   int fails = 0;

   cmp_window_minmax #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_min     (out_min),
      .out_max     (out_max),
      .out_min_idx (out_min_idx),
      .out_max_idx (out_max_idx),
      .out_signed  (out_signed)
`ifdef CMP_WINDOW_RANGE_EN
      ,
      .out_range   (out_range)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int val(input logic [WIDTH-1:0] x, input logic m);
      return m ? int'($signed(x)) : int'(x);
   endfunction

   function automatic res_t calc(input data_q_t q0, input logic [WIDTH-1:0] last_s, input logic m);
      data_q_t q;
      int      mi;
      int      xi;
      res_t    r;
      q = q0;
      q.push_back(last_s);
      mi = 0;
      xi = 0;
      for (int i = 1; i < q.size(); i++) begin
         if (val(q[i], m) < val(q[mi], m)) mi = i;
         if (val(q[i], m) > val(q[xi], m)) xi = i;
      end
      r.mn   = q[mi];
      r.mx   = q[xi];
      r.mn_i = mi;
      r.mx_i = xi;
      r.sg   = m;
      r.rng  = (WIDTH+1)'(val(q[xi], m) - val(q[mi], m));
      return r;
   endfunction

   data_q_t win;
   logic    m_mode;
   logic    m_hold;
   res_t    m_res;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         win.delete();
         m_mode <= 1'b0;
         m_hold <= 1'b0;
         m_res  <= '{mn: '0, mx: '0, mn_i: 0, mx_i: 0, sg: 1'b0, rng: '0};
      end else if (!m_hold) begin
         if (in_valid) begin
            if (win.size() == 0) m_mode <= signed_mode;
            if (win.size() == COUNT - 1) begin
               m_res  <= calc(win, in_data, m_mode);
               m_hold <= 1'b1;
               win.delete();
            end else begin
               win.push_back(in_data);
            end
         end
      end else if (out_ready) begin
         m_hold <= 1'b0;
      end
   end

   // Single compare process, every cycle, away from the active edge.
   always @(negedge clk) begin
      check("cmp_in_ready",  in_ready,  !rst && !m_hold);
      check("cmp_out_valid", out_valid, m_hold);
      check("cmp_min",       out_min,   m_res.mn);
      check("cmp_max",       out_max,   m_res.mx);
      check("cmp_min_idx",   out_min_idx, m_res.mn_i);
      check("cmp_max_idx",   out_max_idx, m_res.mx_i);
      check("cmp_signed",    out_signed, m_res.sg);
`ifdef CMP_WINDOW_RANGE_EN
      check("cmp_range",     out_range,  m_res.rng);
`endif
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive_sample(input logic [WIDTH-1:0] d, input logic m);
      in_valid    = 1'b1;
      in_data     = d;
      signed_mode = m;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, out_valid, 1'b1);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic expect_result(input string name, input logic [WIDTH-1:0] mn, input int mn_i,
                                input logic [WIDTH-1:0] mx, input int mx_i, input logic sg,
                                input logic [WIDTH:0] rng);
      check({name, "_min"},     out_min,     mn);
      check({name, "_min_idx"}, out_min_idx, mn_i);
      check({name, "_max"},     out_max,     mx);
      check({name, "_max_idx"}, out_max_idx, mx_i);
      check({name, "_signed"},  out_signed,  sg);
`ifdef CMP_WINDOW_RANGE_EN
      check({name, "_range"},   out_range,   rng);
`else
      if (rng > '1) check({name, "_range_arg"}, 32'(rng), 32'(rng & '1));
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      signed_mode = 1'b0;
      out_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready",  in_ready,  1'b0);
      expect_result("rst", 8'h00, 0, 8'h00, 0, 1'b0, 9'h000);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1'b1);

      // Signed window with both extremes
      drive_sample(8'hFF, 1'b1);
      drive_sample(8'h01, 1'b1);
      drive_sample(8'h80, 1'b1);
      drive_sample(8'h7F, 1'b1);
      check("signed_latency", out_valid, 1'b1);
      wait_valid("signed_valid");
      expect_result("signed", 8'h80, 2, 8'h7F, 3, 1'b1, 9'h0FF);
      release_result();

      // Same bytes, unsigned
      foreach (win[i]) ;
      drive_sample(8'hFF, 1'b0);
      drive_sample(8'h01, 1'b0);
      drive_sample(8'h80, 1'b0);
      drive_sample(8'h7F, 1'b0);
      wait_valid("unsigned_valid");
      expect_result("unsigned", 8'h01, 1, 8'hFF, 0, 1'b0, 9'h0FE);
      release_result();

      // All ties keep index 0
      repeat (4) drive_sample(8'h05, 1'b0);
      wait_valid("ties_valid");
      expect_result("ties", 8'h05, 0, 8'h05, 0, 1'b0, 9'h000);

      // Back-pressure in HOLD with a pending upstream sample
      in_valid    = 1'b1;
      in_data     = 8'h33;
      signed_mode = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("stall_in_ready",  in_ready,  1'b0);
         check("stall_out_valid", out_valid, 1'b1);
         check("stall_min",       out_min,   8'h05);
         check("stall_max",       out_max,   8'h05);
      end
      release_result();
      check("handshake_out_valid", out_valid, 1'b0);
      check("handshake_in_ready",  in_ready,  1'b1);
      @(posedge clk);
      #1;
      drive_sample(8'h10, 1'b0);
      drive_sample(8'h40, 1'b0);
      drive_sample(8'h20, 1'b0);
      wait_valid("after_stall_valid");
      expect_result("after_stall", 8'h10, 1, 8'h40, 2, 1'b0, 9'h030);
      release_result();

      // Mode toggled after the first sample is ignored
      drive_sample(8'h80, 1'b1);
      drive_sample(8'h10, 1'b0);
      drive_sample(8'h00, 1'b0);
      drive_sample(8'h7F, 1'b0);
      wait_valid("toggle_valid");
      expect_result("toggle", 8'h80, 0, 8'h7F, 3, 1'b1, 9'h0FF);
      release_result();

      // Reset mid-window, asserted between clock edges
      drive_sample(8'h01, 1'b0);
      drive_sample(8'h02, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_in_ready",  in_ready,  1'b0);
      check("midrst_min",       out_min,   8'h00);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_sample(8'h90, 1'b0);
      drive_sample(8'h20, 1'b0);
      drive_sample(8'h50, 1'b0);
      drive_sample(8'h30, 1'b0);
      wait_valid("midrst_valid");
      expect_result("midrst", 8'h20, 1, 8'h90, 0, 1'b0, 9'h070);

      // Reset while holding a result
      #2;
      rst = 1'b1;
      #1;
      check("holdrst_out_valid", out_valid, 1'b0);
      check("holdrst_max",       out_max,   8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_sample(8'hC0, 1'b1);
      drive_sample(8'h40, 1'b1);
      drive_sample(8'hC0, 1'b1);
      drive_sample(8'h40, 1'b1);
      wait_valid("holdrst_valid");
      expect_result("holdrst", 8'hC0, 0, 8'h40, 1, 1'b1, 9'h080);
      release_result();
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_cmp_window_minmax
